hc112_drv: RTL
==============

HC112_DRV -- requirements
Module: hc112_drv

Interface
REQ-001 Parameter SETUP_CYC, default 2: CP cycles J/K held stable before CPN falls; legal 1..15.
REQ-002 Parameter PULSE_CYC, default 2: CP cycles CPN (or force pin) held low; legal 1..15.
REQ-003 Parameter HOLD_CYC, default 1: CP cycles J/K held after CPN rises; legal 1..15.
REQ-004 CP  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 RDN  input  1  reset, asynchronous, active-low.
REQ-006 REQ  input  1  command request, sampled only in IDLE.
REQ-007 CH  input  1  channel select: 0 = flip-flop 1, 1 = flip-flop 2.
REQ-008 OP  input  2  00 hold, 01 clear, 10 set, 11 toggle.
REQ-009 FRC  input  1  1 = use async SDxN/RDxN pins instead of a clock pulse.
REQ-010 Q1, Q2  input  1 each  device Q readback, asynchronous to CP.
REQ-011 J1, K1, J2, K2  output  1 each  JK drive to device.
REQ-012 CPN1, CPN2  output  1 each  device clocks; device captures on falling edge.
REQ-013 SD1N, SD2N, RD1N_O, RD2N_O  output  1 each  device async set/clear, active-low.
REQ-014 BUSY  output  1  high from REQ acceptance until the cycle after ACK.
REQ-015 ACK  output  1  one-cycle completion pulse.
REQ-016 ERR  output  1  readback mismatch, valid with ACK.
REQ-017 QOUT  output  1  synchronized Q of the selected channel, captured at completion.

Function
REQ-018 Q1/Q2 SHALL pass through 2-flop synchronizers before any use.
REQ-019 FSM states: IDLE, SETUP, PULSE, HOLD, SAMPLE, DONE; one 4-bit down-counter times SETUP/PULSE/HOLD/SAMPLE.
REQ-020 IDLE & REQ=1 -> SETUP: latch CH/OP/FRC; EXP = synced Q (hold), 0 (clear), 1 (set), ~Q (toggle).
REQ-021 SETUP: drive J/K of selected channel (00, 01, 10, 11 for hold/clear/set/toggle) for SETUP_CYC cycles -> PULSE.
REQ-022 PULSE: CPNx low for PULSE_CYC cycles; if FRC=1, CPNx stays high and RDxN_O (OP=01) or SDxN (OP=10) goes low instead -> HOLD.
REQ-023 FRC=1 with OP=00 or 11: no pin activity in PULSE; ERR SHALL be set at DONE (both builds).
REQ-024 HOLD: CPNx/force pin high, J/K held for HOLD_CYC cycles -> SAMPLE.
REQ-025 SAMPLE: wait exactly 3 cycles (synchronizer settling), then compare synced Q with EXP -> DONE.
REQ-026 DONE: ACK=1 one cycle, QOUT and ERR updated -> IDLE; J/K return to 0 in IDLE.
REQ-027 Unselected channel pins SHALL remain idle (J/K=0, CPN/SDN/RDN=1) throughout.
REQ-028 REQ while BUSY ignored; REQ held high through DONE starts a new transaction on the first IDLE cycle.
REQ-029 Total latency REQ-accept to ACK = SETUP_CYC+PULSE_CYC+HOLD_CYC+4 cycles.
REQ-030 All device-pin outputs SHALL be registered (glitch-free).

Reset
REQ-031 RDN low SHALL asynchronously force: state IDLE, J/K=0, CPNx=1, SDxN=1, RDxN_O=1, BUSY=0, ACK=0, ERR=0, QOUT=0, synchronizers 0.
REQ-032 Reset mid-PULSE SHALL return CPNx high immediately; no further transaction until REQ after RDN release.

Configuration
REQ-033 Macro HC112_DRV_CHECK_EN: defined -> SAMPLE/compare per REQ-025; undefined -> SAMPLE skipped (HOLD -> DONE), ERR only per REQ-023, QOUT = EXP, latency reduced by 3.

Verification
REQ-034 Reset, CH=0, OP=10, FRC=0, Q1 model follows JK -> J1=1,K1=0 for 2 cycles, CPN1 low 2 cycles, ACK at cycle 11, QOUT=1, ERR=0.
REQ-035 Q1=1, OP=11 toggle x3 -> QOUT 0,1,0; CPN1 three falling edges; CPN2 never toggles.
REQ-036 CH=1, FRC=1, OP=01 -> RD2N_O low 2 cycles, CPN2 stays 1, QOUT=0, ERR=0.
REQ-037 Model holds Q2 stuck at 0, OP=10 on CH=1 (CHECK_EN) -> ACK with ERR=1, QOUT=0.
REQ-038 RDN asserted during PULSE -> CPN1 high same cycle, BUSY=0, no ACK; next REQ completes normally.
REQ-039 FRC=1, OP=11 -> no pin activity, ACK with ERR=1; REQ pulsed during BUSY -> ignored.

Source files
------------

// File: rtl/hc112_drv.sv
// hc112_drv: 74HC112 dual JK flip-flop command sequencer; define HC112_DRV_CHECK_EN to enable synchronized Q readback compare.
module hc112_drv #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       CP,
  input  logic       RDN,
  input  logic       REQ,
  input  logic       CH,
  input  logic [1:0] OP,
  input  logic       FRC,
  input  logic       Q1,
  input  logic       Q2,
  output logic       J1,
  output logic       K1,
  output logic       J2,
  output logic       K2,
  output logic       CPN1,
  output logic       CPN2,
  output logic       SD1N,
  output logic       SD2N,
  output logic       RD1N_O,
  output logic       RD2N_O,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR,
  output logic       QOUT
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] PULSE  = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] SAMPLE = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [1:0] op, q1_s, q2_s;
  logic       ch, frc, exp_q, qs, qa, bad_frc;
  assign qs = ch ? q2_s[1] : q1_s[1];
  assign qa = CH ? q2_s[1] : q1_s[1];
  // forcing has no async pin for hold or toggle, so those can never complete correctly
  assign bad_frc = frc & (op[1] ~^ op[0]);
  always_ff @(posedge CP or negedge RDN) begin
    if (!RDN) begin
      state  <= IDLE;
      cnt    <= '0;
      op     <= '0;
      ch     <= 1'b0;
      frc    <= 1'b0;
      exp_q  <= 1'b0;
      q1_s   <= '0;
      q2_s   <= '0;
      {J1, K1, J2, K2} <= '0;
      {CPN1, CPN2, SD1N, SD2N, RD1N_O, RD2N_O} <= '1;
      BUSY   <= 1'b0;
      ACK    <= 1'b0;
      ERR    <= 1'b0;
      QOUT   <= 1'b0;
    end else begin
      q1_s <= {q1_s[0], Q1};
      q2_s <= {q2_s[0], Q2};
      ACK  <= 1'b0;
      case (state)
        IDLE: if (REQ) begin
          state <= SETUP;
          cnt   <= 4'(SETUP_CYC - 1);
          ch    <= CH;
          op    <= OP;
          frc   <= FRC;
          exp_q <= OP == 2'b00 ? qa : OP == 2'b01 ? 1'b0 : OP == 2'b10 ? 1'b1 : ~qa;
          BUSY  <= 1'b1;
          J1    <= ~CH & OP[1];
          K1    <= ~CH & OP[0];
          J2    <= CH & OP[1];
          K2    <= CH & OP[0];
        end
        SETUP: if (cnt == 4'd0) begin
          state  <= PULSE;
          cnt    <= 4'(PULSE_CYC - 1);
          CPN1   <= ch | frc;
          CPN2   <= ~ch | frc;
          RD1N_O <= ~(~ch & frc & (op == 2'b01));
          SD1N   <= ~(~ch & frc & (op == 2'b10));
          RD2N_O <= ~(ch & frc & (op == 2'b01));
          SD2N   <= ~(ch & frc & (op == 2'b10));
        end else cnt <= cnt - 4'd1;
        PULSE: if (cnt == 4'd0) begin
          state <= HOLD;
          cnt   <= 4'(HOLD_CYC - 1);
          {CPN1, CPN2, SD1N, SD2N, RD1N_O, RD2N_O} <= '1;
        end else cnt <= cnt - 4'd1;
        HOLD: if (cnt == 4'd0) begin
`ifdef HC112_DRV_CHECK_EN
          state <= SAMPLE;
          cnt   <= 4'd2;
`else
          state <= DONE;
          ACK   <= 1'b1;
          QOUT  <= exp_q;
          ERR   <= bad_frc;
`endif
        end else cnt <= cnt - 4'd1;
        SAMPLE: if (cnt == 4'd0) begin
          state <= DONE;
          ACK   <= 1'b1;
          QOUT  <= qs;
          ERR   <= (qs != exp_q) | bad_frc;
        end else cnt <= cnt - 4'd1;
        DONE: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          {J1, K1, J2, K2} <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
